// File: rtl/y86_pkg.sv
// Y86-64 definitions shared by the fetch controller and decode:
// icode constants, instruction length decode and the fetch FSM state type.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRST = 3'd1,
        S_WAIT0 = 3'd2,
        S_REST  = 3'd3,
        S_DONE  = 3'd4
    } fetch_state_e;

    // Returns {invalid, length}; unknown icodes are treated as 1 byte long.
    function automatic logic [4:0] icode_len(input logic [3:0] icode);
        logic [4:0] r;
        case (icode)
            IHALT, INOP, IRET:              r = {1'b0, 4'd1};
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:   r = {1'b0, 4'd2};
            IJXX, ICALL:                    r = {1'b0, 4'd9};
            IIRMOVQ, IRMMOVQ, IMRMOVQ:      r = {1'b0, 4'd10};
            default:                        r = {1'b1, 4'd1};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Request, memory and response signals of the instruction fetch controller.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; valid holds until then.
interface imem_fetch_ctrl_if #(
    parameter int ADDR_W = 64
) ();
    logic              req_valid;
    logic [ADDR_W-1:0] req_pc;
    logic              req_ready;
    logic              flush;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [79:0]       resp_bytes;
    logic [3:0]        resp_len;
    logic              imem_error;
    logic              instr_invalid;

    modport master (
        output req_valid, req_pc, flush, mem_rdata, resp_ready,
        input  req_ready, mem_rd_en, mem_addr, resp_valid, resp_bytes,
               resp_len, imem_error, instr_invalid
    );

    modport slave (
        input  req_valid, req_pc, flush, mem_rdata, resp_ready,
        output req_ready, mem_rd_en, mem_addr, resp_valid, resp_bytes,
               resp_len, imem_error, instr_invalid
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Reads a Y86-64 instruction one byte per cycle from a synchronous byte-wide
// memory, sized by the icode in byte 0, and returns a 10-byte window.
module imem_fetch_ctrl
    import y86_pkg::*;
#(
    parameter int MEM_LAST = 144,
    parameter int ADDR_W   = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_fetch_ctrl_if.slave bus,
    output fetch_state_e dbg_state
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        len_q, len_d;
    logic [79:0]       bytes_q, bytes_d;
    logic              err_q, err_d;
    logic              inv_q, inv_d;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              dec_inv;
    logic [3:0]        dec_len;
    logic [ADDR_W:0]   last_addr;
    logic              pc_oor;

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(MEM_LAST);

    assign {dec_inv, dec_len} = icode_len(bus.mem_rdata[7:4]);
    // One extra bit so PCs near the top of the address space cannot wrap below LAST.
    assign last_addr = {1'b0, pc_q} + (ADDR_W+1)'(dec_len) - (ADDR_W+1)'(1);
    assign pc_oor    = {1'b0, bus.req_pc} > LAST;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        bytes_d = bytes_q;
        err_d   = err_q;
        inv_d   = inv_q;
        rd_en   = 1'b0;
        rd_addr = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    pc_d    = bus.req_pc;
                    bytes_d = '0;
                    cnt_d   = 4'd0;
                    inv_d   = 1'b0;
                    if (pc_oor) begin
                        err_d   = 1'b1;
                        len_d   = 4'd1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        len_d   = 4'd0;
                        state_d = S_FIRST;
                    end
                end
            end
            S_FIRST: begin
                rd_en   = 1'b1;
                rd_addr = pc_q;
                state_d = S_WAIT0;
            end
            S_WAIT0: begin
                bytes_d[7:0] = bus.mem_rdata;
                len_d        = dec_len;
                inv_d        = dec_inv;
                if (dec_len == 4'd1) begin
                    state_d = S_DONE;
                end else if (last_addr > LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = pc_q + ADDR_W'(1);
                    cnt_d   = 4'd1;
                    state_d = S_REST;
                end
            end
            S_REST: begin
                for (int i = 1; i < 10; i++) begin
                    if (cnt_q == 4'(i)) bytes_d[8*i +: 8] = bus.mem_rdata;
                end
                if (cnt_q == len_q - 4'd1) begin
                    state_d = S_DONE;
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = pc_q + ADDR_W'(cnt_q) + ADDR_W'(1);
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything; any read still in flight is simply ignored.
        if (bus.flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= 4'd0;
            len_q   <= 4'd0;
            bytes_q <= '0;
            err_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            bytes_q <= bytes_d;
            err_q   <= err_d;
            inv_q   <= inv_d;
        end
    end

    assign bus.req_ready     = (state_q == S_IDLE) && !bus.flush;
    assign bus.mem_rd_en     = rd_en;
    assign bus.mem_addr      = rd_addr;
    assign bus.resp_valid    = (state_q == S_DONE);
    assign bus.resp_bytes    = bytes_q;
    assign bus.resp_len      = len_q;
    assign bus.imem_error    = err_q;
    assign bus.instr_invalid = inv_q;
    assign dbg_state         = state_q;

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Sequencing controller for the Y86-64 instruction memory. Accepts a fetch request carrying a PC, reads the instruction bytes one per cycle from a synchronous, byte-wide, single-port instruction memory, and sizes the read from the icode in byte 0. Presents a 10-byte instruction window, its length and error flags to the fetch stage through a valid/ready handshake. Sits between the PC-select logic and the instruction memory array, and replaces the direct 10-byte combinational read.

## Interface
- MEM_LAST, 144: highest valid byte address.
- ADDR_W, 64: PC width.
- clk in 1: clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- req_valid in 1: fetch request.
- req_pc in ADDR_W: PC to fetch; sampled on accept.
- req_ready out 1: controller can accept.
- flush in 1: synchronous abort of the current fetch.
- mem_rd_en out 1: memory read strobe.
- mem_addr out ADDR_W: memory byte address.
- mem_rdata in 8: read data, valid the cycle after mem_rd_en.
- resp_valid out 1: window valid; held until resp_ready.
- resp_ready in 1: consumer takes the response.
- resp_bytes out 80: byte i at bits [8i+7:8i]; unfetched bytes are 0.
- resp_len out 4: instruction length, 1..10.
- imem_error out 1: address out of range.
- instr_invalid out 1: icode greater than 0xB.

## Operation
- Length from icode (byte0[7:4]):
  - 0, 1, 9 → 1.
  - 2, 6, A, B → 2.
  - 7, 8 → 9.
  - 3, 4, 5 → 10.
  - Any other icode → 1 and instr_invalid = 1.
- States:
  - IDLE: req_ready = !flush. On accept, latch the PC and clear the byte register. PC > MEM_LAST → DONE with imem_error = 1 and resp_len = 1. Otherwise → FIRST.
  - FIRST: issue a read of the PC. → WAIT0.
  - WAIT0: capture byte 0 and decode L.
    - L = 1 → DONE.
    - PC + L − 1 > MEM_LAST → DONE with imem_error = 1, resp_len = L, only byte 0 populated.
    - Otherwise issue a read of PC+1, set counter = 1, → REST.
  - REST: capture byte[counter]. If counter == L−1 → DONE. Otherwise issue a read of PC+counter+1 and increment the counter.
  - DONE: resp_valid = 1 and all response fields stable. resp_ready → IDLE.
- mem_rd_en and mem_addr are combinational from state, the latched PC and the counter. At most one read is issued per cycle. mem_addr = 0 when no read is issued.
- Address arithmetic is ADDR_W bits wide. The range check uses a 65-bit compare, so PC values near 2^64 flag imem_error and do not wrap.
- flush in any state → IDLE next cycle; resp_valid drops; in-flight read data is discarded. flush overrides a simultaneous req_valid or resp_ready, and no accept occurs.

## Timing
- Reset: state IDLE. req_ready = 1. mem_rd_en, resp_valid, imem_error and instr_invalid = 0. mem_addr, resp_bytes and resp_len = 0.
- Accept in cycle 0 → first read in cycle 1 → byte i captured at the end of cycle i+2 → resp_valid from cycle L+2. Total latency is L+2 cycles: 3 for a 1-byte instruction, 12 for a 10-byte instruction.
- Out-of-range PC: resp_valid from cycle 1, with no memory read.
- Overrun detected on byte 0: resp_valid from cycle 3.
- There is no request overlap. req_ready = 0 in every state except IDLE, so back-to-back fetches cost one idle cycle after the resp_ready handshake.

## Structure
- Shared package y86_pkg:
  - icode constants (IHALT..IPOPQ).
  - the function icode_len(icode) → {invalid, len}, also used by decode.
  - the state enum.
- No sub-module is required. The length decode lives in y86_pkg.

## Test plan
- irmovq at PC 0 (bytes 30 F3 + 8-byte immediate) → 10 reads at addresses 0..9; resp_valid in cycle 12; resp_len = 10; bytes match memory.
- halt (byte 00) at PC 5 → one read; resp_valid in cycle 3; resp_len = 1; resp_bytes[79:8] = 0.
- call at PC 140 (length 9, last byte 148 > 144) → only address 140 is read; resp_valid in cycle 3; imem_error = 1; resp_len = 9.
- req_pc = 200 → no mem_rd_en; resp_valid in cycle 1; imem_error = 1.
- byte 0xC0 → resp_len = 1, instr_invalid = 1. Hold resp_ready low for 5 cycles → resp_valid and all fields stable throughout.
- flush in cycle 4 of a 10-byte fetch → IDLE in cycle 5; no resp_valid; a new request with PC 20 completes correctly. Assert rst_n low mid-fetch → all outputs return to reset values immediately.
